// File: rtl/vga_pkg.sv
// vga_pkg: shared timing presets, colour-bar table and width helper for the VGA output path.
package vga_pkg;

    // 1280x720 @ 60 Hz
    localparam int unsigned P720_H_ACTIVE = 1280;
    localparam int unsigned P720_H_FP     = 110;
    localparam int unsigned P720_H_SW     = 40;
    localparam int unsigned P720_H_BP     = 220;
    localparam int unsigned P720_V_ACTIVE = 720;
    localparam int unsigned P720_V_FP     = 5;
    localparam int unsigned P720_V_SW     = 5;
    localparam int unsigned P720_V_BP     = 20;

    // 640x480 @ 60 Hz
    localparam int unsigned P480_H_ACTIVE = 640;
    localparam int unsigned P480_H_FP     = 16;
    localparam int unsigned P480_H_SW     = 96;
    localparam int unsigned P480_H_BP     = 48;
    localparam int unsigned P480_V_ACTIVE = 480;
    localparam int unsigned P480_V_FP     = 10;
    localparam int unsigned P480_V_SW     = 2;
    localparam int unsigned P480_V_BP     = 33;

    localparam int unsigned N_BARS = 8;

    // Classic colour bars in RGB565, left to right.
    function automatic logic [15:0] bar_rgb565(input logic [2:0] k);
        logic [15:0] c;
        case (k)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/vga_sync_fifo.sv
// vga_sync_fifo: single-clock FIFO with registered read data and occupancy level.
module vga_sync_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    // Caller guarantees push is never issued on full unless pop is issued too.
    assign level = wr_ptr - rd_ptr;
    assign full  = level[AW];
    assign empty = (level == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_stream_out.sv
// vga_stream_out: buffers a pixel stream and drives hsync/vsync/DE timing to the pins.
// Define VGA_TEST_PATTERN_EN to build the colour-bar generator selected by pat_sel.
module vga_stream_out
    import vga_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned H_ACTIVE = P720_H_ACTIVE,
    parameter int unsigned H_FP     = P720_H_FP,
    parameter int unsigned H_SW     = P720_H_SW,
    parameter int unsigned H_BP     = P720_H_BP,
    parameter int unsigned V_ACTIVE = P720_V_ACTIVE,
    parameter int unsigned V_FP     = P720_V_FP,
    parameter int unsigned V_SW     = P720_V_SW,
    parameter int unsigned V_BP     = P720_V_BP,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter int unsigned FIFO_AW  = 7,
    parameter int unsigned LO_WM    = 20,
    parameter int unsigned HI_WM    = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              rdy,
    input  logic              clr_err,
    input  logic              pat_sel,
    output logic [DATA_W-1:0] vga_rgb,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_de,
    output logic              frame_start,
    output logic              underflow,
    output logic              overflow
);
    localparam int unsigned H_TOT = H_SW + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOT = V_SW + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HW    = (clog2(H_TOT) > 0) ? clog2(H_TOT) : 1;
    localparam int unsigned VW    = (clog2(V_TOT) > 0) ? clog2(V_TOT) : 1;
    localparam int unsigned LW    = FIFO_AW + 1;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_SYNC  = HW'(H_SW);
    localparam logic [HW-1:0] H_START = HW'(H_SW + H_BP);
    localparam logic [HW-1:0] H_STOP  = HW'(H_SW + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_SYNC  = VW'(V_SW);
    localparam logic [VW-1:0] V_START = VW'(V_SW + V_BP);
    localparam logic [VW-1:0] V_STOP  = VW'(V_SW + V_BP + V_ACTIVE);
    localparam logic [LW-1:0] LO_LVL  = LW'(LO_WM);
    localparam logic [LW-1:0] HI_LVL  = LW'(HI_WM);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic              hs_c, vs_c, act_c, fs_c;
    logic              pat_now;
    logic [DATA_W-1:0] pat_px;
    logic              push, pop, uf_evt, of_evt;
    logic [DATA_W-1:0] fifo_rd;
    logic              fifo_full, fifo_empty;
    logic [LW-1:0]     fifo_level;
    logic              hs1, vs1, de1, fs1, pop1, pat1;
    logic [DATA_W-1:0] px1;
    logic [DATA_W-1:0] rgb_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        hs_c  = (h_cnt < H_SYNC) ? HS_POL : ~HS_POL;
        vs_c  = (v_cnt < V_SYNC) ? VS_POL : ~VS_POL;
        act_c = (h_cnt >= H_START) && (h_cnt < H_STOP) &&
                (v_cnt >= V_START) && (v_cnt < V_STOP);
        fs_c  = (h_cnt == H_START) && (v_cnt == V_START);
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (H_ACTIVE / N_BARS > 0) ? H_ACTIVE / N_BARS : 1;
    localparam logic [HW-1:0] H_BAR_W = HW'(BAR_W);

    logic          pat_mode;
    logic [HW-1:0] h_off;
    logic [2:0]    bar_idx;

    // pat_sel takes effect at the first active pixel, including that pixel itself.
    always_ff @(posedge clk) begin
        if (rst)       pat_mode <= 1'b0;
        else if (fs_c) pat_mode <= pat_sel;
    end

    always_comb begin
        pat_now = fs_c ? pat_sel : pat_mode;
        h_off   = h_cnt - H_START;
        bar_idx = 3'(h_off / H_BAR_W);
        pat_px  = DATA_W'(bar_rgb565(bar_idx));
    end
`else
    logic unused_pat_sel;

    assign unused_pat_sel = pat_sel;
    assign pat_now        = 1'b0;
    assign pat_px         = '0;
`endif

    // A pop in the same clock frees a slot, so a full FIFO still accepts a word.
    always_comb begin
        pop    = act_c & ~pat_now & ~fifo_empty;
        uf_evt = act_c & ~pat_now & fifo_empty;
        push   = din_vld & (~fifo_full | pop);
        of_evt = din_vld & ~push;
    end

    vga_sync_fifo #(
        .DATA_W (DATA_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (din),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy       <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (fifo_level < LO_LVL)      rdy <= 1'b1;
            else if (fifo_level > HI_LVL) rdy <= 1'b0;
            if (uf_evt)       underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
            if (of_evt)       overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
        end
    end

    // Stage 1 lines timing up with the registered FIFO read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs1  <= ~HS_POL;
            vs1  <= ~VS_POL;
            de1  <= 1'b0;
            fs1  <= 1'b0;
            pop1 <= 1'b0;
            pat1 <= 1'b0;
            px1  <= '0;
        end else begin
            hs1  <= hs_c;
            vs1  <= vs_c;
            de1  <= act_c;
            fs1  <= fs_c;
            pop1 <= pop;
            pat1 <= pat_now;
            px1  <= pat_px;
        end
    end

    always_comb begin
        rgb_c = '0;
        if (de1) begin
            if (pat1)      rgb_c = px1;
            else if (pop1) rgb_c = fifo_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hsync   <= ~HS_POL;
            vga_vsync   <= ~VS_POL;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
            vga_rgb     <= '0;
        end else begin
            vga_hsync   <= hs1;
            vga_vsync   <= vs1;
            vga_de      <= de1;
            frame_start <= fs1;
            vga_rgb     <= rgb_c;
        end
    end

endmodule

// File: tb/tb_vga_stream_out.sv
// tb_vga_stream_out: directed checks of timing, FIFO flow control and sticky flags on a tiny raster.
module tb_vga_stream_out;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_vld;
    logic        clr_err;
    logic        pat_sel;
    logic        rdy;
    logic [15:0] vga_rgb;
    logic        vga_hsync, vga_vsync, vga_de, frame_start, underflow, overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    vga_stream_out #(
        .DATA_W   (16),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SW     (2),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SW     (1),
        .V_BP     (1),
        .HS_POL   (1'b1),
        .VS_POL   (1'b1),
        .FIFO_AW  (4),
        .LO_WM    (4),
        .HI_WM    (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_vld     (din_vld),
        .rdy         (rdy),
        .clr_err     (clr_err),
        .pat_sel     (pat_sel),
        .vga_rgb     (vga_rgb),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_de      (vga_de),
        .frame_start (frame_start),
        .underflow   (underflow),
        .overflow    (overflow)
    );

    // Raster is 14 clocks x 7 lines; pins show the counter state from 2 clocks earlier.
    function automatic logic exp_hs(input int c);
        return ((c - 2) % 14) < 2;
    endfunction
    function automatic logic exp_vs(input int c);
        return (((c - 2) / 14) % 7) < 1;
    endfunction
    function automatic logic exp_de(input int c);
        int h, v;
        h = (c - 2) % 14;
        v = ((c - 2) / 14) % 7;
        return (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
    endfunction
    function automatic logic exp_fs(input int c);
        return (((c - 2) % 14) == 4) && ((((c - 2) / 14) % 7) == 2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; din_vld = 1'b0; din = '0; clr_err = 1'b0; pat_sel = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; din_vld = 1'b0; din = '0; clr_err = 1'b0; pat_sel = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({rdy, vga_hsync, vga_vsync, vga_de, frame_start, underflow, overflow, vga_rgb} !== 23'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b hs=%b vs=%b de=%b fs=%b uf=%b of=%b rgb=%h want all 0",
                     rdy, vga_hsync, vga_vsync, vga_de, frame_start, underflow, overflow, vga_rgb);
        end
        rst = 1'b0;
        cyc = 0;
        step();
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy_rise got %b want 1", rdy);
        end
    endtask

    task automatic test_timing();
        int de_cnt;
        de_cnt = 0;
        do_reset();
        while (cyc < 114) begin
            step();
            if (cyc >= 2) begin
                checks++;
                if ({vga_hsync, vga_vsync, vga_de, frame_start} !==
                    {exp_hs(cyc), exp_vs(cyc), exp_de(cyc), exp_fs(cyc)}) begin
                    errors++;
                    $display("FAIL timing cyc=%0d got hs/vs/de/fs=%b%b%b%b want %b%b%b%b", cyc,
                             vga_hsync, vga_vsync, vga_de, frame_start,
                             exp_hs(cyc), exp_vs(cyc), exp_de(cyc), exp_fs(cyc));
                end
                if (vga_de) de_cnt++;
            end
            if (cyc == 32) begin
                checks++;
                if (underflow !== 1'b0) begin
                    errors++;
                    $display("FAIL underflow_early got %b want 0", underflow);
                end
            end
            if (cyc == 34) begin
                checks++;
                if ({underflow, vga_rgb} !== {1'b1, 16'h0}) begin
                    errors++;
                    $display("FAIL underflow_first_px got uf=%b rgb=%h want uf=1 rgb=0", underflow, vga_rgb);
                end
            end
        end
        checks++;
        if (de_cnt != 32) begin
            errors++;
            $display("FAIL de_per_frame got %0d want 32", de_cnt);
        end
    endtask

    task automatic test_ramp();
        logic [15:0] nxt, px;
        nxt = 16'd0;
        px  = 16'd0;
        do_reset();
        while (cyc < 100) begin
            din_vld = rdy;
            din     = nxt;
            step();
            if (din_vld) nxt++;
            checks++;
            if (exp_de(cyc)) begin
                if (vga_rgb !== px || vga_de !== 1'b1 || frame_start !== exp_fs(cyc)) begin
                    errors++;
                    $display("FAIL ramp_px cyc=%0d got rgb=%h de=%b fs=%b want rgb=%h de=1 fs=%b",
                             cyc, vga_rgb, vga_de, frame_start, px, exp_fs(cyc));
                end
                px++;
            end else if (vga_rgb !== 16'h0) begin
                errors++;
                $display("FAIL ramp_blank cyc=%0d got rgb=%h want 0", cyc, vga_rgb);
            end
        end
        din_vld = 1'b0;
        checks++;
        if ({underflow, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL ramp_flags got uf=%b of=%b want 00", underflow, overflow);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        while (cyc < 60) begin
            din_vld = (cyc < 20);
            din     = 16'(100 + cyc);
            step();
            case (cyc)
                13, 52: begin
                    checks++;
                    if (rdy !== 1'b1) begin
                        errors++;
                        $display("FAIL wm_rdy_high cyc=%0d got %b want 1", cyc, rdy);
                    end
                end
                14, 45, 51: begin
                    checks++;
                    if (rdy !== 1'b0) begin
                        errors++;
                        $display("FAIL wm_rdy_low cyc=%0d got %b want 0", cyc, rdy);
                    end
                end
                16: begin
                    checks++;
                    if (overflow !== 1'b0) begin
                        errors++;
                        $display("FAIL overflow_early got %b want 0", overflow);
                    end
                end
                17: begin
                    checks++;
                    if (overflow !== 1'b1) begin
                        errors++;
                        $display("FAIL overflow_set got %b want 1", overflow);
                    end
                end
                34, 35: begin
                    checks++;
                    if ({vga_de, vga_rgb} !== {1'b1, 16'(66 + cyc)}) begin
                        errors++;
                        $display("FAIL fifo_order cyc=%0d got de=%b rgb=%0d want de=1 rgb=%0d",
                                 cyc, vga_de, vga_rgb, 66 + cyc);
                    end
                end
                default: ;
            endcase
        end
        din_vld = 1'b0;
    endtask

    task automatic test_clr_err();
        do_reset();
        while (cyc < 48) begin
            clr_err = (cyc == 32) || (cyc == 33) || (cyc == 40);
            step();
            if (cyc == 32 || cyc == 41 || cyc == 45) begin
                checks++;
                if (underflow !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_err_low cyc=%0d got %b want 0", cyc, underflow);
                end
            end
            if (cyc == 33 || cyc == 34 || cyc == 47) begin
                checks++;
                if (underflow !== 1'b1) begin
                    errors++;
                    $display("FAIL clr_err_set_wins cyc=%0d got %b want 1", cyc, underflow);
                end
            end
        end
        clr_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        while (cyc < 64) begin
            din_vld = 1'b1;
            din     = 16'(16'h0A00 + cyc);
            step();
        end
        din_vld = 1'b0;
        rst     = 1'b1;
        step();
        checks++;
        if ({rdy, vga_hsync, vga_vsync, vga_de, frame_start, underflow, overflow, vga_rgb} !== 23'h0) begin
            errors++;
            $display("FAIL midreset_state got rdy=%b hs=%b vs=%b de=%b fs=%b uf=%b of=%b rgb=%h want all 0",
                     rdy, vga_hsync, vga_vsync, vga_de, frame_start, underflow, overflow, vga_rgb);
        end
        rst = 1'b0;
        cyc = 0;
        while (cyc < 34) begin
            step();
            if (cyc == 2 || cyc == 4) begin
                checks++;
                if (vga_hsync !== (cyc == 2)) begin
                    errors++;
                    $display("FAIL midreset_restart cyc=%0d got hs=%b want %b", cyc, vga_hsync, cyc == 2);
                end
            end
        end
        checks++;
        if ({vga_de, underflow, vga_rgb} !== {1'b1, 1'b1, 16'h0}) begin
            errors++;
            $display("FAIL midreset_fifo_empty got de=%b uf=%b rgb=%h want de=1 uf=1 rgb=0",
                     vga_de, underflow, vga_rgb);
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    function automatic logic [15:0] bar_ref(input int k);
        logic [15:0] t [8];
        t = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        return t[k];
    endfunction

    task automatic test_pattern();
        do_reset();
        while (cyc < 200) begin
            if (cyc == 50) pat_sel = 1'b1;
            clr_err = (cyc == 90);
            step();
            if (cyc >= 76 && cyc <= 83) begin
                checks++;
                if (vga_rgb !== 16'h0) begin
                    errors++;
                    $display("FAIL pat_same_frame cyc=%0d got %h want 0", cyc, vga_rgb);
                end
            end
            if (cyc >= 132 && cyc <= 139) begin
                checks++;
                if (vga_rgb !== bar_ref(cyc - 132)) begin
                    errors++;
                    $display("FAIL pat_bar cyc=%0d got %h want %h", cyc, vga_rgb, bar_ref(cyc - 132));
                end
            end
        end
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL pat_no_underflow got %b want 0", underflow);
        end
        pat_sel = 1'b0;
        clr_err = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_timing();
        test_ramp();
        test_overflow();
        test_clr_err();
        test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
